// File: rtl/xdma_write_issuer.sv
// xdma_write_issuer: turns burst descriptors plus a data stream into
// AXI AW/W bursts and tracks outstanding B responses.
module xdma_write_issuer #(
  parameter int AddrWidth      = 48,
  parameter int DataWidth      = 512,
  parameter int MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 desc_valid_i,
  output logic                 desc_ready_o,
  input  logic [AddrWidth-1:0] desc_addr_i,
  input  logic [7:0]           desc_len_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [AddrWidth-1:0] aw_addr_o,
  output logic [7:0]           aw_len_o,
  output logic                 w_valid_o,
  input  logic                 w_ready_i,
  output logic [DataWidth-1:0] w_data_o,
  output logic                 w_last_o,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic [1:0]           b_resp_i,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int CntW = 4;
  localparam logic [CntW-1:0] MaxOut = CntW'(MaxOutstanding);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           len_q;
  logic [7:0]           beat_q;
  logic [CntW-1:0]      outst_q;
  logic                 err_q;
  logic                 done_q;

  logic desc_hs;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic last_beat;
  logic stray_b;

  assign desc_hs   = desc_valid_i & desc_ready_o;
  assign aw_hs     = aw_valid_o & aw_ready_i;
  assign w_hs      = w_valid_o & w_ready_i;
  assign b_hs      = b_valid_i & b_ready_o;
  assign last_beat = (beat_q == len_q);
  assign stray_b   = b_hs & (outst_q == '0);

  assign aw_addr_o = addr_q;
  assign aw_len_o  = len_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: IDLE -> AW on descriptor, AW -> W on AW handshake,
  // W -> IDLE on the last-beat handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (desc_hs) state_d = S_AW;
      S_AW:    if (aw_hs) state_d = S_W;
      S_W:     if (w_hs && last_beat) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: W channel is a pass-through gated by the W state;
  // ready outputs are forced low while reset is held
  always_comb begin
    desc_ready_o = 1'b0;
    aw_valid_o   = 1'b0;
    w_valid_o    = 1'b0;
    data_ready_o = 1'b0;
    w_last_o     = 1'b0;
    w_data_o     = data_i;
    b_ready_o    = ~rst_i;
    unique case (state_q)
      S_IDLE: desc_ready_o = ~rst_i & (outst_q < MaxOut);
      S_AW:   aw_valid_o   = 1'b1;
      S_W: begin
        w_valid_o    = data_valid_i;
        data_ready_o = w_ready_i;
        w_last_o     = last_beat;
      end
      default: ;
    endcase
  end

  // Descriptor capture; payload holds stable through the AW phase
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      len_q  <= '0;
    end else if (desc_hs) begin
      addr_q <= desc_addr_i;
      len_q  <= desc_len_i;
    end
  end

  // Beat counter: cleared by the AW handshake, steps per W beat
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      beat_q <= '0;
    else if (aw_hs) beat_q <= '0;
    else if (w_hs)  beat_q <= beat_q + 8'd1;
  end

  // Outstanding bursts; a B with nothing outstanding is not counted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_q <= '0;
    end else begin
      unique case ({aw_hs, b_hs & ~stray_b})
        2'b10:   outst_q <= outst_q + CntW'(1);
        2'b01:   outst_q <= outst_q - CntW'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  // Completion pulse and sticky error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= b_hs;
      if (b_hs && ((b_resp_i != 2'b00) || stray_b)) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xdma_write_issuer.sv
// tb_xdma_write_issuer: scenario tasks driving random data and
// comparing observed AXI traffic against a queue-based model.
module tb_xdma_write_issuer;

  localparam int AW = 48;
  localparam int DW = 512;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          desc_valid_i = 1'b0;
  logic          desc_ready_o;
  logic [AW-1:0] desc_addr_i = '0;
  logic [7:0]    desc_len_i = '0;
  logic          data_valid_i = 1'b0;
  logic          data_ready_o;
  logic [DW-1:0] data_i = '0;
  logic          aw_valid_o;
  logic          aw_ready_i = 1'b0;
  logic [AW-1:0] aw_addr_o;
  logic [7:0]    aw_len_o;
  logic          w_valid_o;
  logic          w_ready_i = 1'b0;
  logic [DW-1:0] w_data_o;
  logic          w_last_o;
  logic          b_valid_i = 1'b0;
  logic          b_ready_o;
  logic [1:0]    b_resp_i = 2'b00;
  logic          done_o;
  logic          err_o;

  int errors = 0;
  int checks = 0;
  int outst = 0;

  logic [DW-1:0]   pat [256];
  logic [AW+7:0]   aw_q [$];
  logic [DW-1:0]   wd_q [$];
  logic            wl_q [$];
  int              open_bursts = 0;
  int              early_w = 0;

  xdma_write_issuer #(
    .AddrWidth(AW),
    .DataWidth(DW),
    .MaxOutstanding(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .desc_valid_i(desc_valid_i),
    .desc_ready_o(desc_ready_o),
    .desc_addr_i(desc_addr_i),
    .desc_len_i(desc_len_i),
    .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o),
    .data_i(data_i),
    .aw_valid_o(aw_valid_o),
    .aw_ready_i(aw_ready_i),
    .aw_addr_o(aw_addr_o),
    .aw_len_o(aw_len_o),
    .w_valid_o(w_valid_o),
    .w_ready_i(w_ready_i),
    .w_data_o(w_data_o),
    .w_last_o(w_last_o),
    .b_valid_i(b_valid_i),
    .b_ready_o(b_ready_o),
    .b_resp_i(b_resp_i),
    .done_o(done_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Observe handshakes mid-cycle; they complete at the next rising edge
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (aw_valid_o && aw_ready_i) begin
        aw_q.push_back({aw_len_o, aw_addr_o});
        open_bursts++;
      end
      if (w_valid_o && w_ready_i) begin
        if (open_bursts == 0) early_w++;
        wd_q.push_back(w_data_o);
        wl_q.push_back(w_last_o);
        if (w_last_o && open_bursts > 0) open_bursts--;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill_pat();
    for (int i = 0; i < 256; i++)
      for (int k = 0; k < DW / 32; k++)
        pat[i][k*32 +: 32] = $urandom;
  endtask

  task automatic clear_obs();
    aw_q.delete();
    wd_q.delete();
    wl_q.delete();
    early_w = 0;
  endtask

  task automatic send_desc(input logic [AW-1:0] a, input logic [7:0] l);
    int n;
    n = 0;
    desc_valid_i = 1'b1;
    desc_addr_i  = a;
    desc_len_i   = l;
    forever begin
      @(negedge clk_i);
      if (desc_ready_o) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL desc_timeout: desc_ready_o=%b after %0d cycles, required 1", desc_ready_o, n);
        break;
      end
      step();
    end
    step();
    desc_valid_i = 1'b0;
  endtask

  task automatic do_aw();
    int n;
    n = 0;
    aw_ready_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (aw_valid_o) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL aw_timeout: aw_valid_o=%b, required 1", aw_valid_o);
        break;
      end
      step();
    end
    step();
    aw_ready_i = 1'b0;
  endtask

  task automatic do_w(input int l, input int pv, input int pr);
    int beat;
    int n;
    beat = 0;
    n = 0;
    while (beat <= l) begin
      data_i       = pat[beat];
      data_valid_i = (int'($urandom_range(99)) < pv);
      w_ready_i    = (int'($urandom_range(99)) < pr);
      @(negedge clk_i);
      if (w_valid_o && w_ready_i) beat++;
      n++;
      if (n > 5000) begin
        checks++;
        errors++;
        $display("FAIL w_timeout: beats=%0d, required %0d", beat, l + 1);
        break;
      end
      step();
    end
    data_valid_i = 1'b0;
    w_ready_i    = 1'b0;
  endtask

  task automatic drive_burst(input logic [AW-1:0] a, input logic [7:0] l,
                             input int pv, input int pr);
    send_desc(a, l);
    do_aw();
    do_w(int'(l), pv, pr);
    outst++;
  endtask

  task automatic send_b(input logic [1:0] r);
    b_valid_i = 1'b1;
    b_resp_i  = r;
    step();
    b_valid_i = 1'b0;
    b_resp_i  = 2'b00;
    if (outst > 0) outst--;
  endtask

  task automatic test_reset();
    data_valid_i = 1'b1;
    w_ready_i    = 1'b1;
    #3;
    checks++;
    if (desc_ready_o !== 1'b0) begin errors++;
      $display("FAIL rst_desc_ready: got %b want 0", desc_ready_o); end
    checks++;
    if (aw_valid_o !== 1'b0) begin errors++;
      $display("FAIL rst_aw_valid: got %b want 0", aw_valid_o); end
    checks++;
    if (w_valid_o !== 1'b0 || data_ready_o !== 1'b0) begin errors++;
      $display("FAIL rst_w: w_valid=%b data_ready=%b want 0 0", w_valid_o, data_ready_o); end
    checks++;
    if (done_o !== 1'b0 || err_o !== 1'b0) begin errors++;
      $display("FAIL rst_flags: done=%b err=%b want 0 0", done_o, err_o); end
    data_valid_i = 1'b0;
    w_ready_i    = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (desc_ready_o !== 1'b1 || b_ready_o !== 1'b1) begin errors++;
      $display("FAIL rst_release: desc_ready=%b b_ready=%b want 1 1", desc_ready_o, b_ready_o); end
    step();
  endtask

  task automatic test_basic();
    logic [AW+7:0] exp_aw;
    clear_obs();
    fill_pat();
    drive_burst(48'h0000_1000_0000, 8'd3, 100, 100);
    exp_aw = {8'd3, 48'h0000_1000_0000};
    checks++;
    if (aw_q.size() != 1 || aw_q[0] !== exp_aw) begin errors++;
      $display("FAIL basic_aw: count=%0d want 1", aw_q.size()); end
    checks++;
    if (wd_q.size() != 4) begin errors++;
      $display("FAIL basic_beats: got %0d want 4", wd_q.size()); end
    for (int i = 0; i < wd_q.size() && i < 4; i++) begin
      checks++;
      if (wd_q[i] !== pat[i] || wl_q[i] !== (i == 3)) begin errors++;
        $display("FAIL basic_beat%0d: last=%b want %b", i, wl_q[i], i == 3); end
    end
    b_valid_i = 1'b1;
    b_resp_i  = 2'b00;
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0) begin errors++;
      $display("FAIL basic_done_early: got %b want 0", done_o); end
    step();
    b_valid_i = 1'b0;
    outst--;
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b1) begin errors++;
      $display("FAIL basic_done: got %b want 1", done_o); end
    step();
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0 || err_o !== 1'b0) begin errors++;
      $display("FAIL basic_done_pulse: done=%b err=%b want 0 0", done_o, err_o); end
    step();
  endtask

  task automatic test_len0();
    logic [AW-1:0] a;
    int bad;
    clear_obs();
    fill_pat();
    a = {16'h0, $urandom};
    send_desc(a, 8'd0);
    data_i       = pat[0];
    data_valid_i = 1'b1;
    w_ready_i    = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      aw_ready_i = (k == 5);
      @(negedge clk_i);
      checks++;
      if (aw_valid_o !== 1'b1 || aw_addr_o !== a || aw_len_o !== 8'd0) begin
        errors++;
        $display("FAIL len0_aw_stable%0d: valid=%b len=%0d want 1 0", k, aw_valid_o, aw_len_o);
      end
      checks++;
      if (w_valid_o !== 1'b0 || data_ready_o !== 1'b0) begin errors++;
        $display("FAIL len0_no_w%0d: w_valid=%b data_ready=%b want 0 0", k, w_valid_o, data_ready_o); end
      step();
    end
    aw_ready_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (w_valid_o !== 1'b1 || w_last_o !== 1'b1 || w_data_o !== pat[0]) begin errors++;
      $display("FAIL len0_beat: w_valid=%b w_last=%b want 1 1", w_valid_o, w_last_o); end
    step();
    data_valid_i = 1'b0;
    w_ready_i    = 1'b0;
    @(negedge clk_i);
    checks++;
    if (wd_q.size() != 1 || aw_q.size() != 1 || early_w != 0) begin errors++;
      $display("FAIL len0_counts: beats=%0d aws=%0d early=%0d want 1 1 0", wd_q.size(), aw_q.size(), early_w); end
    step();
    outst++;
    send_b(2'b00);
  endtask

  task automatic test_outstanding();
    clear_obs();
    fill_pat();
    for (int b = 0; b < 4; b++)
      drive_burst(48'h2000 + 48'(b * 64), 8'd1, 100, 100);
    @(negedge clk_i);
    checks++;
    if (aw_q.size() != 4) begin errors++;
      $display("FAIL out_aw4: got %0d want 4", aw_q.size()); end
    checks++;
    if (desc_ready_o !== (outst < 4)) begin errors++;
      $display("FAIL out_full_ready: got %b want %b", desc_ready_o, outst < 4); end
    step();
    fork
      drive_burst(48'h9000, 8'd1, 100, 100);
      begin
        repeat (10) @(posedge clk_i);
        #2;
        checks++;
        if (aw_q.size() != 4 || desc_ready_o !== 1'b0) begin errors++;
          $display("FAIL out_stall: aws=%0d desc_ready=%b want 4 0", aw_q.size(), desc_ready_o); end
        b_valid_i = 1'b1;
        @(posedge clk_i);
        #1 b_valid_i = 1'b0;
        outst--;
      end
    join
    checks++;
    if (aw_q.size() != 5 || aw_q[aw_q.size()-1] !== {8'd1, 48'h9000}) begin errors++;
      $display("FAIL out_fifth: aws=%0d want 5", aw_q.size()); end
    while (outst > 0) send_b(2'b00);
  endtask

  task automatic test_err();
    drive_burst(48'h3000, 8'd0, 100, 100);
    send_b(2'b10);
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b1) begin errors++;
      $display("FAIL err_slverr: got %b want 1", err_o); end
    step();
    drive_burst(48'h3100, 8'd0, 100, 100);
    send_b(2'b00);
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b1) begin errors++;
      $display("FAIL err_sticky: got %b want 1", err_o); end
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    outst = 0;
    open_bursts = 0;
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b0) begin errors++;
      $display("FAIL err_reset: got %b want 0", err_o); end
    step();
    send_b(2'b00);
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b1 || desc_ready_o !== 1'b1) begin errors++;
      $display("FAIL err_stray: err=%b desc_ready=%b want 1 1", err_o, desc_ready_o); end
    step();
    for (int b = 0; b < 4; b++) begin
      drive_burst(48'h4000 + 48'(b * 64), 8'd0, 100, 100);
      @(negedge clk_i);
      checks++;
      if (desc_ready_o !== (outst < 4)) begin errors++;
        $display("FAIL err_nounderflow%0d: desc_ready=%b want %b", b, desc_ready_o, outst < 4); end
      step();
    end
    while (outst > 0) send_b(2'b00);
  endtask

  task automatic test_long();
    clear_obs();
    fill_pat();
    drive_burst(48'hABCD_0000, 8'd255, 60, 70);
    checks++;
    if (wd_q.size() != 256 || early_w != 0) begin errors++;
      $display("FAIL long_beats: got %0d early=%0d want 256 0", wd_q.size(), early_w); end
    for (int i = 0; i < wd_q.size() && i < 256; i++) begin
      checks++;
      if (wd_q[i] !== pat[i] || wl_q[i] !== (i == 255)) begin errors++;
        $display("FAIL long_beat%0d: last=%b want %b", i, wl_q[i], i == 255); end
    end
    send_b(2'b00);
  endtask

  task automatic test_back_to_back();
    int cnt;
    clear_obs();
    fill_pat();
    drive_burst(48'h5000, 8'd2, 100, 100);
    desc_valid_i = 1'b1;
    desc_addr_i  = 48'h5100;
    desc_len_i   = 8'd2;
    cnt = 0;
    forever begin
      @(negedge clk_i);
      cnt++;
      if (aw_valid_o || cnt > 20) break;
      step();
    end
    step();
    desc_valid_i = 1'b0;
    checks++;
    if (cnt != 2) begin errors++;
      $display("FAIL b2b_gap: cycles to aw_valid=%0d want 2", cnt); end
    do_aw();
    do_w(2, 100, 100);
    outst++;
    checks++;
    if (aw_q.size() != 2 || wd_q.size() != 6 || aw_q[1] !== {8'd2, 48'h5100}) begin errors++;
      $display("FAIL b2b_traffic: aws=%0d beats=%0d want 2 6", aw_q.size(), wd_q.size()); end
    while (outst > 0) send_b(2'b00);
  endtask

  task automatic test_reset_mid();
    int beat;
    int nbeats;
    clear_obs();
    fill_pat();
    send_desc(48'h6000, 8'd7);
    do_aw();
    beat = 0;
    for (int n = 0; n < 20; n++) begin
      data_i       = pat[beat];
      data_valid_i = 1'b1;
      w_ready_i    = 1'b1;
      if (beat == 2) break;
      @(negedge clk_i);
      if (w_valid_o && w_ready_i) beat++;
      step();
    end
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if (aw_valid_o !== 1'b0 || w_valid_o !== 1'b0 || data_ready_o !== 1'b0) begin errors++;
      $display("FAIL mid_abort: aw=%b w=%b dr=%b want 0 0 0", aw_valid_o, w_valid_o, data_ready_o); end
    checks++;
    if (desc_ready_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin errors++;
      $display("FAIL mid_flags: desc_ready=%b done=%b err=%b want 0 0 0", desc_ready_o, done_o, err_o); end
    nbeats = wd_q.size();
    repeat (3) step();
    checks++;
    if (wd_q.size() != nbeats || nbeats != 2 || aw_q.size() != 1) begin errors++;
      $display("FAIL mid_quiet: beats=%0d aws=%0d want 2 1", wd_q.size(), aw_q.size()); end
    data_valid_i = 1'b0;
    w_ready_i    = 1'b0;
    rst_i        = 1'b0;
    outst        = 0;
    open_bursts  = 0;
    @(negedge clk_i);
    checks++;
    if (desc_ready_o !== 1'b1) begin errors++;
      $display("FAIL mid_release: desc_ready=%b want 1", desc_ready_o); end
    step();
    clear_obs();
    drive_burst(48'h7000, 8'd2, 100, 100);
    checks++;
    if (aw_q.size() != 1 || aw_q[0] !== {8'd2, 48'h7000} || wd_q.size() != 3) begin errors++;
      $display("FAIL mid_next: aws=%0d beats=%0d want 1 3", aw_q.size(), wd_q.size()); end
    for (int i = 0; i < wd_q.size() && i < 3; i++) begin
      checks++;
      if (wd_q[i] !== pat[i] || wl_q[i] !== (i == 2)) begin errors++;
        $display("FAIL mid_beat%0d: last=%b want %b", i, wl_q[i], i == 2); end
    end
    send_b(2'b00);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_outstanding();
    test_err();
    test_long();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
